// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule tables, state encoding and rotate/permute helpers
package des_pkg;
  localparam int NUM_ROUNDS = 16;
  localparam int KEY_W      = 64;
  localparam int SUBKEY_W   = 48;
  localparam int HALF_W     = 28;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Tables list 1-based source bit numbers, bit 1 being the MSB
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam logic [1:0] SHIFT_TABLE [NUM_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [2*HALF_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [2*HALF_W-1:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction
endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational PC-2 compression of {C,D} into a 48-bit round subkey
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);
  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) subkey[47-i] = cd[56-PC2[i]];
  end
endmodule

// File: rtl/des_subkey_sequencer.sv
// rtl/des_subkey_sequencer.sv - round subkey sequencer with ack handshake, encrypt and decrypt order
module des_subkey_sequencer
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [63:0] key_in,
  input  logic        start,
  input  logic        decrypt,
  input  logic        round_ack,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_number,
  output logic        busy,
  output logic        cycle_complete
);
  state_t      state, state_n;
  logic [27:0] c0, d0, c, d;
  logic [3:0]  idx;
  logic        dir;
  logic [1:0]  shamt;
  logic [3:0]  idx_next, idx_rev;
  logic [47:0] pc2_out;

  des_pc2 u_pc2 (.cd({c, d}), .subkey(pc2_out));

  // Encrypt looks one entry ahead; decrypt walks the table backwards
  assign idx_next = idx + 4'd1;
  assign idx_rev  = 4'd15 - idx;
  assign shamt    = dir ? SHIFT_TABLE[idx_rev] : SHIFT_TABLE[idx_next];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !key_load) state_n = ROUND;
      ROUND:   if (round_ack && idx == 4'd15) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0  <= '0;
      d0  <= '0;
      c   <= '0;
      d   <= '0;
      idx <= '0;
      dir <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            {c0, d0} <= pc1(key_in);
          end else if (start) begin
            dir <= decrypt;
            idx <= '0;
            // Decrypt starts at K16, whose cumulative shift of 28 is the identity
            c   <= decrypt ? c0 : rotl28(c0, SHIFT_TABLE[0]);
            d   <= decrypt ? d0 : rotl28(d0, SHIFT_TABLE[0]);
          end
        end
        ROUND: begin
          if (round_ack && idx != 4'd15) begin
            idx <= idx_next;
            c   <= dir ? rotr28(c, shamt) : rotl28(c, shamt);
            d   <= dir ? rotr28(d, shamt) : rotl28(d, shamt);
          end
        end
        default: idx <= '0;
      endcase
    end
  end

  assign subkey_valid   = (state == ROUND);
  assign subkey         = subkey_valid ? pc2_out : 48'h0;
  assign round_number   = subkey_valid ? idx : 4'd0;
  assign busy           = (state != IDLE);
  assign cycle_complete = (state == DONE);
endmodule

// File: tb/tb_des_subkey_sequencer.sv
// tb/tb_des_subkey_sequencer.sv - directed bench for des_subkey_sequencer against a reference key schedule
module tb_des_subkey_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        key_load;
  logic [63:0] key_in;
  logic        start;
  logic        decrypt;
  logic        round_ack;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_number;
  logic        busy;
  logic        cycle_complete;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  int t_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int t_pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int t_shift [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_subkey_sequencer dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .start(start), .decrypt(decrypt), .round_ack(round_ack),
    .subkey(subkey), .subkey_valid(subkey_valid), .round_number(round_number),
    .busy(busy), .cycle_complete(cycle_complete));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Kn from the cumulative left shift applied directly to C0/D0
  function automatic logic [47:0] ref_key(input logic [63:0] k, input int n);
    logic [27:0] cc, dd;
    logic [55:0] cd;
    logic [47:0] o;
    int tot;
    for (int i = 0; i < 28; i++) begin
      cc[27-i] = k[64-t_pc1[i]];
      dd[27-i] = k[64-t_pc1[i+28]];
    end
    tot = 0;
    for (int j = 0; j < n; j++) tot += t_shift[j];
    tot = tot % 28;
    cc = (cc << tot) | (cc >> (28 - tot));
    dd = (dd << tot) | (dd >> (28 - tot));
    cd = {cc, dd};
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-t_pc2[i]];
    return o;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {63'h0, busy}, 64'h0);
    check({tag, "_valid"}, {63'h0, subkey_valid}, 64'h0);
    check({tag, "_subkey"}, {16'h0, subkey}, 64'h0);
    check({tag, "_round"}, {60'h0, round_number}, 64'h0);
    check({tag, "_done"}, {63'h0, cycle_complete}, 64'h0);
  endtask

  task automatic load_key(input logic [63:0] k);
    key_load = 1'b1;
    key_in   = k;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  // Runs a full sequence; stall_at/collide_at < 0 disable those perturbations
  task automatic run_seq(input logic [63:0] key, input logic dec, input int stall_at, input int collide_at);
    int kidx;
    logic [47:0] exp_k;
    start   = 1'b1;
    decrypt = dec;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 16; r++) begin
      kidx  = dec ? 16 - r : r + 1;
      exp_k = ref_key(key, kidx);
      if (r == stall_at) begin
        for (int s = 0; s < 5; s++) begin
          check("stall_subkey", {16'h0, subkey}, {16'h0, exp_k});
          check("stall_round", {60'h0, round_number}, r);
          @(negedge clk);
        end
      end
      check("valid", {63'h0, subkey_valid}, 64'h1);
      check("busy", {63'h0, busy}, 64'h1);
      check("round", {60'h0, round_number}, r);
      check("subkey", {16'h0, subkey}, {16'h0, exp_k});
      check("no_done", {63'h0, cycle_complete}, 64'h0);
      if (key == KEY_A && kidx == 1)  check("k1_const", {16'h0, subkey}, 64'h1B02EFFC7072);
      if (key == KEY_A && kidx == 2)  check("k2_const", {16'h0, subkey}, 64'h79AED9DBC9E5);
      if (key == KEY_A && kidx == 16) check("k16_const", {16'h0, subkey}, 64'hCB3D8B0E17F5);
      round_ack = 1'b1;
      if (r == collide_at) begin
        start    = 1'b1;
        decrypt  = ~dec;
        key_load = 1'b1;
        key_in   = ~key;
      end
      @(negedge clk);
      round_ack = 1'b0;
      start     = 1'b0;
      key_load  = 1'b0;
    end
    check("done_pulse", {63'h0, cycle_complete}, 64'h1);
    check("done_busy", {63'h0, busy}, 64'h1);
    check("done_valid", {63'h0, subkey_valid}, 64'h0);
    check("done_subkey", {16'h0, subkey}, 64'h0);
    start   = 1'b1;
    decrypt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_idle("after_done");
  endtask

  initial begin
    rst = 1'b1; key_load = 1'b0; key_in = '0;
    start = 1'b0; decrypt = 1'b0; round_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    load_key(KEY_A);
    run_seq(KEY_A, 1'b0, -1, -1);
    run_seq(KEY_A, 1'b1, -1, -1);
    run_seq(KEY_A, 1'b0, 7, -1);
    run_seq(KEY_A, 1'b0, -1, 3);
    run_seq(KEY_A, 1'b1, 7, -1);

    start = 1'b1; key_load = 1'b1; key_in = KEY_B; decrypt = 1'b0;
    @(negedge clk);
    start = 1'b0; key_load = 1'b0;
    check_idle("load_start");
    run_seq(KEY_B, 1'b0, -1, -1);

    start = 1'b1; decrypt = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 9; r++) begin
      round_ack = 1'b1;
      @(negedge clk);
      round_ack = 1'b0;
    end
    check("pre_rst_round", {60'h0, round_number}, 64'd9);
    #2 rst = 1'b1;
    #1 check_idle("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_seq(64'h0, 1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
